// File: rtl/dmem_req_ctrl.sv
// rtl/dmem_req_ctrl.sv - data-cache memory request controller: line refills, store write buffer, refill/store hazard
module dmem_req_ctrl #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int LINE_OFFSET_BITS = 5,
  parameter int WBUF_DEPTH       = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_refill_req,
  input  logic [ADDR_WIDTH-1:0]       i_refill_addr,
  output logic                        o_refill_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_refill_line,
  input  logic                        i_store_valid,
  input  logic [ADDR_WIDTH-1:0]       i_store_addr,
  input  logic [DATA_WIDTH-1:0]       i_store_data,
  input  logic [7:0]                  i_store_strobe,
  output logic                        o_store_ready,
  output logic                        o_wbuf_empty,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  output logic                        o_mem_read_req,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_mem_write_valid,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [7:0]                  o_write_strobe,
  input  logic                        i_mem_write_done
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [ADDR_WIDTH-1:0]       r_wb_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]       r_wb_data [WBUF_DEPTH];
  logic [7:0]                  r_wb_strb [WBUF_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W:0]              r_count;
  logic [ADDR_WIDTH-1:0]       r_read_addr;
  logic [CACHE_LINE_WIDTH-1:0] r_refill_line;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_hazard;
  logic [PTR_W-1:0]            w_off;

  assign o_store_ready = (r_count != (PTR_W+1)'(WBUF_DEPTH));
  assign w_push        = i_store_valid && o_store_ready;
  assign w_pop         = (r_state == S_WRITE) && i_mem_write_done;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= i_store_addr;
      r_wb_data[r_wr_ptr] <= i_store_data;
      r_wb_strb[r_wr_ptr] <= i_store_strobe;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the count; the head stays live while its write is in flight.
  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) &&
          (r_wb_addr[i][ADDR_WIDTH-1:LINE_OFFSET_BITS] == i_refill_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS]))
        w_hazard = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_refill_req && !w_hazard) w_next = S_READ;
        else if (r_count != '0)        w_next = S_WRITE;
      end
      S_READ:  if (i_mem_read_done)  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_WRITE: if (i_mem_write_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_addr   <= '0;
      r_refill_line <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_READ)
        r_read_addr <= {i_refill_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
      if (r_state == S_READ && i_mem_read_done)
        r_refill_line <= i_cache_line;
    end
  end

  always_comb begin
    o_mem_read_req      = (r_state == S_READ);
    o_mem_read_address  = r_read_addr;
    o_refill_done       = (r_state == S_RESP);
    o_refill_line       = r_refill_line;
    o_wbuf_empty        = (r_count == '0) && (r_state != S_WRITE);
    o_mem_write_valid   = 1'b0;
    o_mem_write_data    = '0;
    o_mem_write_address = '0;
    o_write_strobe      = '0;
    if (r_state == S_WRITE) begin
      o_mem_write_valid   = 1'b1;
      o_mem_write_data    = r_wb_data[r_rd_ptr];
      o_mem_write_address = r_wb_addr[r_rd_ptr];
      o_write_strobe      = r_wb_strb[r_rd_ptr];
    end
  end

endmodule
